// File: rtl/synchronizer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : synchronizer_pkg
// Brief    : Shared types and helpers for the OFDM frame extractor.
// Revision : 1.0 - initial release
// ============================================================================
package synchronizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFSET = 2'd1,
        ST_CP     = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    localparam int c_last_per_symbol = 0;
    localparam int c_last_per_frame  = 1;

    function automatic int tkeep_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo
// Brief    : Synchronous first-word-fall-through FIFO with a registered output
//            stage; the output register counts toward the DEPTH capacity.
// Revision : 1.0 - initial release
// ============================================================================
module frame_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_rd_ready
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_mem_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_pop;
    logic             w_load;
    logic             w_wr;
    logic [c_aw:0]    w_occ;

    assign w_occ   = r_mem_cnt + (c_aw + 1)'(r_out_valid);
    assign o_full  = (w_occ == c_depth);
    assign o_empty = !r_out_valid;
    assign w_pop   = r_out_valid && i_rd_ready;
    // A pop in the same cycle frees the slot a full FIFO needs for the write.
    assign w_wr    = i_wr_en && (!o_full || w_pop);
    assign w_load  = (!r_out_valid || i_rd_ready) && (r_mem_cnt != '0);

    assign o_rd_data = r_out_data;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + c_aw'(1);
                r_out_data  <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            case ({w_wr, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + (c_aw + 1)'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - (c_aw + 1)'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofdm_frame_extractor.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_frame_extractor
// Brief    : Skips a trigger offset after a correlation peak, then strips the
//            cyclic prefix of each OFDM symbol and streams NFFT samples per
//            symbol through a FWFT FIFO to a back-pressured AXI-Stream port.
// Config   : SYNC_RETRIGGER_EN - a trigger in OFFSET, or in CP of symbol 0,
//            re-latches the configuration and restarts the offset.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_frame_extractor
    import synchronizer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NFFT_W     = 12,
    parameter int SYM_W      = 4,
    parameter int OFFSET_W   = 10,
    parameter int FIFO_DEPTH = 1024,
    parameter int LAST_MODE  = 0
) (
    input  logic                           axis_aclk,
    input  logic                           axis_aresetn,
    input  logic [DATA_W-1:0]              s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           i_max_sync,
    input  logic [NFFT_W-1:0]              i_nfft,
    input  logic [NFFT_W-1:0]              i_cp_len,
    input  logic [SYM_W-1:0]               i_symbols,
    input  logic [OFFSET_W-1:0]            i_trig_offset,
    output logic [DATA_W-1:0]              m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [tkeep_width(DATA_W)-1:0] m_axis_tkeep,
    output logic                           o_busy,
    output logic                           o_overflow,
    output logic [SYM_W-1:0]               o_sym_idx
);

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_start_state;

    logic [NFFT_W-1:0]   r_nfft;
    logic [NFFT_W-1:0]   r_cp_len;
    logic [SYM_W-1:0]    r_symbols;
    logic [OFFSET_W-1:0] r_offset;
    logic [OFFSET_W-1:0] r_off_cnt;
    logic [NFFT_W-1:0]   r_cp_cnt;
    logic [NFFT_W-1:0]   r_data_cnt;
    logic [SYM_W-1:0]    r_sym_idx;
    logic                r_overflow;

    logic                w_cfg_ok;
    logic                w_retrig;
    logic                w_trig;
    logic                w_off_done;
    logic                w_cp_done;
    logic                w_data_last;
    logic                w_last_sym;
    logic                w_tag_gate;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_fifo_ready;
    logic                w_wr_en;
    logic                w_ovf;
    logic                w_tag;
    logic [DATA_W:0]     w_rd_data;

    assign w_cfg_ok      = (i_symbols != '0) && (i_nfft != '0);
    assign w_start_state = (i_trig_offset != '0) ? ST_OFFSET :
                           (i_cp_len != '0)      ? ST_CP     : ST_DATA;

`ifdef SYNC_RETRIGGER_EN
    assign w_retrig = i_max_sync &&
                      ((r_state == ST_OFFSET) || ((r_state == ST_CP) && (r_sym_idx == '0)));
`else
    assign w_retrig = 1'b0;
`endif

    assign w_trig      = ((r_state == ST_IDLE) && i_max_sync) || w_retrig;
    assign w_off_done  = s_axis_tvalid && (r_off_cnt == r_offset - OFFSET_W'(1));
    assign w_cp_done   = s_axis_tvalid && (r_cp_cnt == r_cp_len - NFFT_W'(1));
    assign w_data_last = (r_data_cnt == r_nfft - NFFT_W'(1));
    assign w_last_sym  = (r_sym_idx == r_symbols - SYM_W'(1));
    assign w_fifo_ready = !w_fifo_full || (!w_fifo_empty && m_axis_tready);

    generate
        if (LAST_MODE == c_last_per_frame) begin : g_last_frame
            assign w_tag_gate = w_last_sym;
        end else begin : g_last_symbol
            assign w_tag_gate = 1'b1;
        end
    endgenerate

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_max_sync && w_cfg_ok) begin
                    w_next_state = w_start_state;
                end
            end
            ST_OFFSET: begin
                if (w_retrig) begin
                    w_next_state = w_cfg_ok ? w_start_state : ST_IDLE;
                end else if (w_off_done) begin
                    w_next_state = (r_cp_len != '0) ? ST_CP : ST_DATA;
                end
            end
            ST_CP: begin
                if (w_retrig) begin
                    w_next_state = w_cfg_ok ? w_start_state : ST_IDLE;
                end else if (w_cp_done) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_ovf) begin
                    w_next_state = ST_IDLE;
                end else if (s_axis_tvalid && w_data_last) begin
                    if (w_last_sym) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = (r_cp_len != '0) ? ST_CP : ST_DATA;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en = 1'b0;
        w_ovf   = 1'b0;
        w_tag   = 1'b0;
        o_busy  = (r_state != ST_IDLE);
        if ((r_state == ST_DATA) && s_axis_tvalid) begin
            w_wr_en = w_fifo_ready;
            w_ovf   = !w_fifo_ready;
            w_tag   = w_data_last && w_tag_gate;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_nfft     <= '0;
            r_cp_len   <= '0;
            r_symbols  <= '0;
            r_offset   <= '0;
            r_off_cnt  <= '0;
            r_cp_cnt   <= '0;
            r_data_cnt <= '0;
            r_sym_idx  <= '0;
            r_overflow <= 1'b0;
        end else if (w_trig) begin
            r_nfft     <= i_nfft;
            r_cp_len   <= i_cp_len;
            r_symbols  <= i_symbols;
            r_offset   <= i_trig_offset;
            r_off_cnt  <= '0;
            r_cp_cnt   <= '0;
            r_data_cnt <= '0;
            r_sym_idx  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_OFFSET: begin
                    if (s_axis_tvalid) begin
                        r_off_cnt <= w_off_done ? '0 : r_off_cnt + OFFSET_W'(1);
                    end
                end
                ST_CP: begin
                    if (s_axis_tvalid) begin
                        r_cp_cnt <= w_cp_done ? '0 : r_cp_cnt + NFFT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_ovf) begin
                        r_data_cnt <= '0;
                    end else if (s_axis_tvalid) begin
                        if (w_data_last) begin
                            r_data_cnt <= '0;
                            if (!w_last_sym) begin
                                r_sym_idx <= r_sym_idx + SYM_W'(1);
                            end
                        end else begin
                            r_data_cnt <= r_data_cnt + NFFT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    frame_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (axis_aclk),
        .rst_n      (axis_aresetn),
        .i_wr_en    (w_wr_en),
        .i_wr_data  ({w_tag, s_axis_tdata}),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_rd_data  (w_rd_data),
        .i_rd_ready (m_axis_tready)
    );

    // The tag bit stays in the output register after a pop; gate it by valid.
    assign m_axis_tvalid = !w_fifo_empty;
    assign m_axis_tdata  = w_rd_data[DATA_W-1:0];
    assign m_axis_tlast  = !w_fifo_empty && w_rd_data[DATA_W];
    assign m_axis_tkeep  = '1;
    assign o_overflow    = r_overflow;
    assign o_sym_idx     = r_sym_idx;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_frame_extractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofdm_frame_extractor
// Brief    : Scoreboard bench; one instance per tlast mode, shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofdm_frame_extractor;

    localparam int DW = 32, NW = 12, SW = 4, OW = 10, DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid, sync, ready;
    logic [NW-1:0] cfg_nfft, cfg_cp;
    logic [SW-1:0] cfg_sym;
    logic [OW-1:0] cfg_off;

    logic [DW-1:0] a_tdata, b_tdata;
    logic          a_tvalid, b_tvalid, a_tlast, b_tlast;
    logic [3:0]    a_tkeep, b_tkeep;
    logic          a_busy, b_busy, a_ovf, b_ovf;
    logic [SW-1:0] a_sym, b_sym;

    always #5 clk = ~clk;

    ofdm_frame_extractor #(.DATA_W(DW), .NFFT_W(NW), .SYM_W(SW), .OFFSET_W(OW),
                           .FIFO_DEPTH(DEPTH), .LAST_MODE(0)) dut_a (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
        .i_max_sync(sync), .i_nfft(cfg_nfft), .i_cp_len(cfg_cp), .i_symbols(cfg_sym),
        .i_trig_offset(cfg_off), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(ready), .m_axis_tlast(a_tlast), .m_axis_tkeep(a_tkeep),
        .o_busy(a_busy), .o_overflow(a_ovf), .o_sym_idx(a_sym));

    ofdm_frame_extractor #(.DATA_W(DW), .NFFT_W(NW), .SYM_W(SW), .OFFSET_W(OW),
                           .FIFO_DEPTH(DEPTH), .LAST_MODE(1)) dut_b (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
        .i_max_sync(sync), .i_nfft(cfg_nfft), .i_cp_len(cfg_cp), .i_symbols(cfg_sym),
        .i_trig_offset(cfg_off), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(ready), .m_axis_tlast(b_tlast), .m_axis_tkeep(b_tkeep),
        .o_busy(b_busy), .o_overflow(b_ovf), .o_sym_idx(b_sym));

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last_sym;
        logic          last_frame;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_fail = 0, n_beats = 0;

    // Reference model: position of each beat within the frame, by arithmetic.
    bit m_active = 0, m_ovf = 0;
    int m_cons, m_n, m_cp, m_s, m_off;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready && (a_tvalid || b_tvalid)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got tvalid=1 data=%0h, expected no beat (t=%0t)",
                         a_tdata, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("a_tvalid", a_tvalid, 1);
                chk("a_tdata", a_tdata, e.data);
                chk("a_tlast", a_tlast, e.last_sym);
                chk("a_tkeep", a_tkeep, 4'hF);
                chk("b_tvalid", b_tvalid, 1);
                chk("b_tdata", b_tdata, e.data);
                chk("b_tlast", b_tlast, e.last_frame);
                chk("b_tkeep", b_tkeep, 4'hF);
                n_beats++;
            end
        end
    end

    function automatic int cur_sym();
        int per, k;
        per = m_cp + m_n;
        if (m_cons < m_off) return 0;
        k = (m_cons - m_off) / per;
        return (k > m_s - 1) ? m_s - 1 : k;
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d, input logic sy, input logic rd);
        int   rel, per, pos, sym;
        exp_t e;
        s_valid = v; s_data = d; sync = sy; ready = rd;
        if (sy && !m_active) begin
            m_n = int'(cfg_nfft); m_cp = int'(cfg_cp); m_s = int'(cfg_sym); m_off = int'(cfg_off);
            m_ovf = 0; m_cons = 0;
            m_active = (m_n != 0) && (m_s != 0);
        end else if (m_active && v) begin
            per = m_cp + m_n;
            rel = m_cons - m_off;
            if (rel >= 0) begin
                sym = rel / per;
                pos = rel % per;
                if (pos >= m_cp) begin
                    if (q.size() >= DEPTH && !rd) begin
                        m_ovf = 1;
                        m_active = 0;
                    end else begin
                        e.data = d;
                        e.last_sym = (pos == per - 1);
                        e.last_frame = (pos == per - 1) && (sym == m_s - 1);
                        q.push_back(e);
                    end
                end
            end
            m_cons++;
            if (m_cons == m_off + m_s * per) m_active = 0;
        end
        @(posedge clk);
        #1;
        chk("a_busy", a_busy, m_active);
        chk("b_busy", b_busy, m_active);
        chk("a_overflow", a_ovf, m_ovf);
        if (m_active) chk("a_sym_idx", a_sym, cur_sym());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0; sync = 1'b0;
        #1;
        chk("rst_tvalid", a_tvalid, 0);
        chk("rst_tlast", a_tlast, 0);
        chk("rst_tdata", a_tdata, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_overflow", a_ovf, 0);
        chk("rst_sym_idx", a_sym, 0);
        chk("rst_b_tvalid", b_tvalid, 0);
        chk("rst_b_busy", b_busy, 0);
        q.delete();
        m_active = 0; m_ovf = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() > 0; i++) step(0, '0, 0, 1);
        chk("drain_timeout", q.size(), 0);
        repeat (3) step(0, '0, 0, 1);
    endtask

    // Counter stream, one sample every 5 cycles, trigger after sample 20.
    task automatic counter_frame(input int abort_cons);
        bit trig_sent = 0;
        int c;
        cfg_nfft = 7; cfg_cp = 3; cfg_sym = 9; cfg_off = 64;
        for (c = 0; c < 3000; c++) begin
            if (trig_sent && !m_active) break;
            if (abort_cons >= 0 && m_active && m_cons == abort_cons) begin
                do_reset();
                return;
            end
            step((c % 5) == 0, DW'(c / 5), (c == 101), 1);
            if (c == 101) trig_sent = 1;
        end
        chk("frame_timeout", c < 3000, 1);
    endtask

    task automatic run_until_idle(input int vpct, input int rpct, input bit poke);
        int g;
        for (g = 0; g < 1500 && m_active; g++) begin
            step($urandom_range(99) < vpct, $urandom, poke && ($urandom_range(99) < 5),
                 $urandom_range(99) < rpct);
        end
        chk("frame_timeout", g < 1500, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; s_valid = 0; s_data = '0; sync = 0; ready = 1;
        cfg_nfft = '0; cfg_cp = '0; cfg_sym = '0; cfg_off = '0;
        #3;
        do_reset();

        n_beats = 0;
        counter_frame(-1);
        drain();
        chk("base_beats", n_beats, 63);

        // Backpressure overflow
        cfg_nfft = 32; cfg_cp = 0; cfg_sym = 1; cfg_off = 0;
        step(0, '0, 1, 0);
        for (int i = 0; i < 40 && m_active; i++) step(1, $urandom, 0, 0);
        chk("ovf_flag", a_ovf, 1);
        repeat (4) step(1, $urandom, 0, 0);
        n_beats = 0;
        drain();
        chk("ovf_drain_beats", n_beats, 16);

        // Minimal frame; its trigger also clears the overflow flag
        cfg_nfft = 4; cfg_cp = 0; cfg_sym = 1; cfg_off = 0;
        step(0, '0, 1, 1);
        chk("ovf_cleared", a_ovf, 0);
        run_until_idle(60, 100, 0);
        drain();

        // Second trigger 10 beats into OFFSET
        cfg_nfft = 7; cfg_cp = 3; cfg_sym = 2; cfg_off = 64;
        step(0, '0, 1, 1);
        while (m_active && m_cons < 10) step(1, DW'(1000 + m_cons), 0, 1);
        step(1, DW'(1000 + m_cons), 1, 1);
        while (m_active) step(1, DW'(1000 + m_cons), 0, 1);
        drain();

        // Reset during DATA of symbol 3, then a clean frame
        counter_frame(64 + 3 * 10 + 3 + 2);
        repeat (20) step(1, $urandom, 0, 1);
        n_beats = 0;
        counter_frame(-1);
        drain();
        chk("post_reset_beats", n_beats, 63);

        for (int f = 0; f < 12; f++) begin
            cfg_nfft = NW'($urandom_range(8));
            cfg_cp   = NW'($urandom_range(4));
            cfg_sym  = SW'($urandom_range(4));
            cfg_off  = OW'($urandom_range(12));
            step($urandom_range(1), $urandom, 1, 1);
            run_until_idle(50, 75, 1);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
